// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RISC-V sequencer:
// FSM states, opcodes, ALU codes and datapath mux encodings.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECUTER,
      S_EXECUTEI,
      S_ALUWB,
      S_BEQ,
      S_JAL
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_BAD = 3'b111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Immediate format depends only on the opcode, independent of the FSM state.
   function automatic logic [1:0] imm_src_of(input logic [6:0] op);
      case (op)
         OP_SW:   return 2'b01;
         OP_BEQ:  return 2'b10;
         OP_JAL:  return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// mux selects and write enables out.
interface multicycle_control_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7;
   logic       Zero;
   logic       mem_ready;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;
   logic [1:0] ImmSrc;
   logic       RegWrite;
   logic       retire;
   logic       illegal;

   modport master (
      input  op, funct3, funct7, Zero, mem_ready,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, retire, illegal
   );

   modport slave (
      output op, funct3, funct7, Zero, mem_ready,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, retire, illegal
   );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALUOp plus instruction
// fields onto the shared ALU's operation code.
module multicycle_control_alu_decoder
   import multicycle_control_pkg::*;
(
   input  alu_op_e    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       op5,
   output logic [2:0] alu_control
);

   always_comb begin
      // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
      alu_control = ALU_BAD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // op5 separates R-type from I-type so addi never subtracts
               3'b000:  alu_control = (op5 & funct7) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_BAD;
            endcase
         end
         default: alu_control = ALU_BAD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer walking each instruction through fetch/decode/execute/
// memory/writeback, stalling on mem_ready in the memory-access states.
module multicycle_control
   import multicycle_control_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master bus
);

   state_e     state_q, state_d;
   alu_op_e    alu_op;
   logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write;
   logic       retire, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      pc_update  = 1'b0;
      branch     = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            result_src = RES_ALURESULT;
            alu_src_b  = SRCB_FOUR;
            ir_write   = bus.mem_ready;
            pc_update  = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
                  retire  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src   = 1'b1;
            mem_write = 1'b1;
            if (bus.mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXECUTER, S_EXECUTEI: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RS1;
            alu_op    = ALUOP_SUB;
            branch    = 1'b1;
            retire    = 1'b1;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_update = 1'b1;
            state_d   = S_ALUWB;
         end
         default: state_d = S_FETCH;
      endcase
   end

   multicycle_control_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (bus.funct3),
      .funct7      (bus.funct7),
      .op5         (bus.op[5]),
      .alu_control (bus.ALUControl)
   );

   // Enables are gated by rst_n so nothing writes while reset is held,
   // even in FETCH where IRWrite/PCWrite follow mem_ready.
   assign bus.PCWrite   = rst_n & (pc_update | (branch & bus.Zero));
   assign bus.IRWrite   = rst_n & ir_write;
   assign bus.MemWrite  = rst_n & mem_write;
   assign bus.RegWrite  = rst_n & reg_write;
   assign bus.retire    = rst_n & retire;
   assign bus.illegal   = rst_n & illegal;
   assign bus.AdrSrc    = adr_src;
   assign bus.ResultSrc = result_src;
   assign bus.ALUSrcA   = alu_src_a;
   assign bus.ALUSrcB   = alu_src_b;
   assign bus.ImmSrc    = imm_src_of(bus.op);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases followed by
// random instruction streams against a per-instruction cycle-script model.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef enum {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILL} kind_e;

   typedef struct packed {
      logic       pc_write;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_control;
      logic [1:0] imm_src;
      logic       reg_write;
      logic       retire;
      logic       illegal;
   } ctl_t;

   typedef struct packed {
      logic       mr;
      logic       z;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
   } drv_t;

   drv_t drv_q[$];
   ctl_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic ctl_t mk(input logic pcw, input logic adr, input logic memw,
                               input logic irw, input logic [1:0] res,
                               input logic [1:0] sa, input logic [1:0] sb,
                               input logic [2:0] aluc, input logic regw,
                               input logic ret, input logic ill,
                               input logic [1:0] imm);
      ctl_t c;
      c.pc_write    = pcw;
      c.adr_src     = adr;
      c.mem_write   = memw;
      c.ir_write    = irw;
      c.result_src  = res;
      c.alu_src_a   = sa;
      c.alu_src_b   = sb;
      c.alu_control = aluc;
      c.imm_src     = imm;
      c.reg_write   = regw;
      c.retire      = ret;
      c.illegal     = ill;
      return c;
   endfunction

   function automatic ctl_t observe();
      return mk(bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite,
                bus.retire, bus.illegal, bus.ImmSrc);
   endfunction

   function automatic logic [6:0] op_of(input kind_e k);
      case (k)
         K_LW:    return 7'b0000011;
         K_SW:    return 7'b0100011;
         K_R:     return 7'b0110011;
         K_I:     return 7'b0010011;
         K_BEQ:   return 7'b1100011;
         K_JAL:   return 7'b1101111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [1:0] imm_of(input kind_e k);
      case (k)
         K_SW:    return 2'b01;
         K_BEQ:   return 2'b10;
         K_JAL:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Arithmetic-op mnemonic table: add/sub/slt/or/and, anything else is 111.
   function automatic logic [2:0] alu_of(input kind_e k, input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  return (k == K_R && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b111;
      endcase
   endfunction

   task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic mr, input logic z, input logic [6:0] op,
                       input logic [2:0] f3, input logic f7, input ctl_t e);
      drv_t d;
      d.mr = mr; d.z = z; d.op = op; d.f3 = f3; d.f7 = f7;
      drv_q.push_back(d);
      exp_q.push_back(e);
   endtask

   // Builds the per-cycle script of one instruction: inputs to drive and outputs expected.
   task automatic model_instr(input kind_e k, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input int fstall, input int mstall,
                              input logic zb);
      logic [1:0] im;
      logic       ill;
      im  = imm_of(k);
      ill = (k == K_ILL);
      for (int i = 0; i < fstall; i++)
         push(1'b0, rb(), op, f3, f7, mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0, im));
      push(1'b1, rb(), op, f3, f7, mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0, im));
      push(rb(), rb(), op, f3, f7, mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0, ill, ill, im));
      case (k)
         K_LW, K_SW: begin
            push(rb(), rb(), op, f3, f7, mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0, 0, im));
            for (int i = 0; i < mstall; i++)
               push(1'b0, rb(), op, f3, f7,
                    mk(0, 1, k == K_SW, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, im));
            if (k == K_LW) begin
               push(1'b1, rb(), op, f3, f7, mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, im));
               push(rb(), rb(), op, f3, f7, mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 1, 1, 0, im));
            end else begin
               push(1'b1, rb(), op, f3, f7, mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 1, 0, im));
            end
         end
         K_R, K_I: begin
            push(rb(), rb(), op, f3, f7, mk(0, 0, 0, 0, 2'b00, 2'b10, (k == K_R) ? 2'b00 : 2'b01,
                                            alu_of(k, f3, f7), 0, 0, 0, im));
            push(rb(), rb(), op, f3, f7, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0, im));
         end
         K_BEQ:
            push(rb(), zb, op, f3, f7, mk(zb, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0, 1, 0, im));
         K_JAL: begin
            push(rb(), rb(), op, f3, f7, mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0, 0, 0, im));
            push(rb(), rb(), op, f3, f7, mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1, 0, im));
         end
         default: ;
      endcase
   endtask

   task automatic run_queue(input int n, input string tag);
      drv_t d;
      ctl_t e;
      for (int i = 0; i < n && exp_q.size() > 0; i++) begin
         @(negedge clk);
         d = drv_q.pop_front();
         e = exp_q.pop_front();
         bus.mem_ready = d.mr;
         bus.Zero      = d.z;
         bus.op        = d.op;
         bus.funct3    = d.f3;
         bus.funct7    = d.f7;
         #1;
         check($sformatf("%s c%0d", tag, i + 1), observe(), e);
      end
   endtask

   task automatic do_instr(input kind_e k, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int fstall, input int mstall,
                           input logic zb, input string tag);
      model_instr(k, op, f3, f7, fstall, mstall, zb);
      run_queue(100, tag);
   endtask

   logic [2:0] f3_pool [6] = '{3'b000, 3'b010, 3'b110, 3'b111, 3'b001, 3'b100};

   initial begin
      kind_e      k;
      logic [6:0] op;
      logic [2:0] f3;

      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;
      bus.Zero      = 1'b0;
      bus.op        = 7'b0110011;
      bus.funct3    = 3'b000;
      bus.funct7    = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset_state", observe(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0, 2'b00));
      bus.mem_ready = 1'b0;
      rst_n         = 1'b1;

      do_instr(K_R, 7'b0110011, 3'b000, 1'b0, 0, 0, 1'b0, "add");
      do_instr(K_R, 7'b0110011, 3'b000, 1'b1, 0, 0, 1'b0, "sub");
      do_instr(K_I, 7'b0010011, 3'b000, 1'b1, 0, 0, 1'b0, "addi_f7");
      do_instr(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b1, "beq_taken");
      do_instr(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 1'b0, "beq_not_taken");
      do_instr(K_LW, 7'b0000011, 3'b010, 1'b0, 0, 3, 1'b0, "lw_stall3");
      do_instr(K_ILL, 7'b1111111, 3'b000, 1'b0, 0, 0, 1'b0, "illegal");
      do_instr(K_JAL, 7'b1101111, 3'b000, 1'b0, 2, 0, 1'b0, "jal_fstall");

      // Abort a store stalled in MEMWRITE with reset.
      model_instr(K_SW, 7'b0100011, 3'b010, 1'b0, 0, 3, 1'b0);
      run_queue(4, "sw_abort");
      drv_q.delete();
      exp_q.delete();
      @(negedge clk);
      bus.mem_ready = 1'b1;
      rst_n         = 1'b0;
      #1;
      check("rst_in_memwrite", observe(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0, 2'b01));
      @(negedge clk);
      #1;
      check("rst_held", observe(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0, 2'b01));
      bus.mem_ready = 1'b0;
      rst_n         = 1'b1;
      do_instr(K_SW, 7'b0100011, 3'b010, 1'b0, 0, 1, 1'b0, "sw_after_rst");

      for (int n = 0; n < 150; n++) begin
         k  = kind_e'($urandom_range(0, 6));
         f3 = f3_pool[$urandom_range(0, 5)];
         if (k == K_ILL) begin
            do op = 7'($urandom);
            while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b1100011, 7'b1101111});
         end else begin
            op = op_of(k);
         end
         do_instr(k, op, f3, rb(), $urandom_range(0, 2), $urandom_range(0, 3), rb(),
                  $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the RISC-V core: a Moore FSM that walks each instruction through fetch, decode, execute, memory and writeback steps. It drives the mux selects and write enables of a datapath that shares one ALU and one memory port across cycles. It supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal. A memory-ready handshake lets it stall on slow memory.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instruction opcode from the instruction register
- funct3  in  3  instruction funct3
- funct7  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
- ALUControl  out  3  ALU operation code
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- RegWrite  out  1  register file write enable
- retire  out  1  single-cycle pulse on the final cycle of each instruction
- illegal  out  1  single-cycle pulse on decode of an unsupported opcode

## Operation
- Unlisted outputs in each state are 0. ALUOp is an internal 2-bit field.
- FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=mem_ready.
  - mem_ready=1: go to DECODE.
  - mem_ready=0: hold in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other opcode -> FETCH, with illegal=1 and retire=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Go to MEMWB when mem_ready=1, else hold.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1. Go to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite stays high while stalled.
  - When mem_ready=1: retire=1, go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire=1. Go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, retire=1. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is decoded from op alone:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - otherwise 00
- ALU decode (ALUControl):
  - ALUOp 00 -> 000 (add)
  - ALUOp 01 -> 001 (sub)
  - ALUOp 10, funct3 000: 001 if op[5]&funct7, else 000 (so addi never subtracts)
  - ALUOp 10, funct3 010 -> 101 (slt)
  - ALUOp 10, funct3 110 -> 011 (or)
  - ALUOp 10, funct3 111 -> 010 (and)
  - all other combinations -> 111

## Timing
- Cycles per instruction with mem_ready=1 throughout:
  - lw: 5
  - sw: 4
  - R-type: 4
  - I-type: 4
  - jal: 4
  - beq: 3
  - illegal: 2
- Each low cycle of mem_ready in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Outputs depend only on the current state, op/funct and Zero/mem_ready. There is no output register.
- Reset:
  - While rst_n=0: state=FETCH, and PCWrite, IRWrite, RegWrite, MemWrite, retire and illegal are forced 0. Mux selects take their FETCH values.
  - Reset asserted mid-instruction aborts it immediately. No partial write completes after assertion.
  - First FETCH is the first rising edge after rst_n deasserts.
- Zero is sampled only in BEQ. Changes to op/funct outside DECODE, MEMADR, EXECUTE and BEQ have no effect.

## Structure
- Shared package holds:
  - state enum (11 states)
  - opcode constants
  - ALUControl codes
  - ALUSrcA/ALUSrcB/ResultSrc encodings
- Natural sub-module: combinational alu_decoder (inputs ALUOp, funct3, funct7, op[5]; output ALUControl).

## Test plan
- add (op 0110011, funct3 000, funct7 0): states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000 in EXECUTER; RegWrite=1 and retire=1 only in cycle 4.
- sub (funct7=1) -> ALUControl=001. addi with funct7=1 (op 0010011) -> ALUControl=000.
- beq: Zero=1 -> PCWrite=1 in cycle 3. Zero=0 -> PCWrite stays 0 in cycle 3. retire=1 in both cases.
- lw with mem_ready=0 for 3 cycles in MEMREAD -> 8 total cycles, a single RegWrite pulse with ResultSrc=01.
- Opcode 1111111 -> illegal=1 and retire=1 in DECODE, back to FETCH, no RegWrite, MemWrite or PCWrite.
- rst_n low during stalled MEMWRITE -> MemWrite drops to 0 the same cycle; FETCH on the first edge after release.
